// File: rtl/keypad_entry.sv
// Keypad digit-entry stage: edge-detected presses edit a 4-digit BCD buffer.
// Enter converts the buffer to binary and offers it on a valid/ready handshake.
module keypad_entry #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            key,
  input  logic                  pressed,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   digits,
  output logic [2:0]            count,
  output logic [13:0]           out_bin,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  key_drop
);

  typedef enum logic [1:0] {COLLECT, CONVERT, HOLD} state_t;

  state_t      state;
  logic        pressed_d;
  logic [13:0] acc;
  logic [1:0]  idx;
  logic        press_ev;
  logic [3:0]  dsel;
  logic [13:0] acc_next;

  assign press_ev = pressed & ~pressed_d;
  assign dsel     = digits[{idx, 2'b00} +: 4];
  // acc*10 as two shifts; 9999 is the largest result so 14 bits never overflow
  assign acc_next = (acc << 3) + (acc << 1) + {10'd0, dsel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      pressed_d <= 1'b0;
      acc       <= '0;
      idx       <= 2'd3;
      digits    <= '0;
      count     <= '0;
      out_bin   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      key_drop  <= 1'b0;
    end else begin
      pressed_d <= pressed;
      key_drop  <= 1'b0;
      case (state)
        COLLECT: begin
          if (press_ev) begin
            if (key < 4'd10) begin
              if (count < 3'd4) begin
                digits <= {digits[4*DIGITS-5:0], key};
                count  <= count + 3'd1;
              end else begin
                key_drop <= 1'b1;
              end
            end else begin
              case (key)
                4'hA: begin
                  if (count != 3'd0) begin
                    state <= CONVERT;
                    busy  <= 1'b1;
                    acc   <= '0;
                    idx   <= 2'd3;
                  end else begin
                    key_drop <= 1'b1;
                  end
                end
                4'hB: begin
                  if (count != 3'd0) begin
                    digits <= {4'h0, digits[4*DIGITS-1:4]};
                    count  <= count - 3'd1;
                  end else begin
                    key_drop <= 1'b1;
                  end
                end
                4'hC: begin
                  digits <= '0;
                  count  <= '0;
                end
                default: key_drop <= 1'b1;
              endcase
            end
          end
        end
        CONVERT: begin
          if (press_ev) key_drop <= 1'b1;
          acc <= acc_next;
          idx <= idx - 2'd1;
          if (idx == 2'd0) begin
            out_bin   <= acc_next;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // a press on the transfer edge is still seen in HOLD and dropped
          if (press_ev) key_drop <= 1'b1;
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            digits    <= '0;
            count     <= '0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
